// File: rtl/regfile_mp_if.sv
// regfile_mp_if: groups the read, write and PC signals of the multi-port
// register file into one bundle.
//   slave  modport - used by regfile_mp (ready_o, rd_dat_o, pc_o are outputs)
//   master modport - used by the CPU control logic driving the file
// Signals:
//   ready_o   1                 register file initialised and usable
//   rd_en_i   NUM_RD            per-port read enable
//   rd_id_i   NUM_RD*AW         per-port index, port k at [k*AW +: AW]
//   rd_dat_o  NUM_RD*DAT_WIDTH  per-port read data, port k at [k*DAT_WIDTH +: DAT_WIDTH]
//   we_i      1                 write enable
//   wr_id_i   AW                write index
//   wr_dat_i  DAT_WIDTH         write data
//   pc_inc_i  1                 advance PC by one word
//   pc_o      DAT_WIDTH         current PC contents
interface regfile_mp_if #(
    parameter int DAT_WIDTH = 64,
    parameter int NUM_REGS  = 32,
    parameter int NUM_RD    = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic                        ready_o;
    logic [NUM_RD-1:0]           rd_en_i;
    logic [NUM_RD*AW-1:0]        rd_id_i;
    logic [NUM_RD*DAT_WIDTH-1:0] rd_dat_o;
    logic                        we_i;
    logic [AW-1:0]               wr_id_i;
    logic [DAT_WIDTH-1:0]        wr_dat_i;
    logic                        pc_inc_i;
    logic [DAT_WIDTH-1:0]        pc_o;

    modport slave (
        output ready_o, rd_dat_o, pc_o,
        input  rd_en_i, rd_id_i, we_i, wr_id_i, wr_dat_i, pc_inc_i
    );

    modport master (
        input  ready_o, rd_dat_o, pc_o,
        output rd_en_i, rd_id_i, we_i, wr_id_i, wr_dat_i, pc_inc_i
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with NUM_RD synchronous read ports,
// one write port, a registered PC output and a PC auto-increment.
// After reset the file clears itself one register per cycle (the PC register
// gets PC_RESET); ready_o rises once the sweep is complete.
// Ports:
//   clk_i    in   clock, rising edge
//   rst_n_i  in   synchronous active-low reset
//   bus      slave modport of regfile_mp_if (read/write/PC signals)
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writes
// (and a lone PC increment) to the read ports. Without it, reads issued on
// the same edge as a write return the pre-edge contents.
module regfile_mp #(
    parameter int          DAT_WIDTH     = 64,
    parameter int          NUM_REGS      = 32,
    parameter int          NUM_RD        = 2,
    parameter int          PC_REG        = NUM_REGS - 1,
    parameter logic [63:0] PC_RESET      = 64'h0000_8000_0000_0000,
    parameter bit          HARDWIRE_ZERO = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    regfile_mp_if.slave bus
);
    localparam int AW = $clog2(NUM_REGS);
    localparam logic [DAT_WIDTH-1:0] PC_RST_VAL = DAT_WIDTH'(PC_RESET);
    localparam logic [DAT_WIDTH-1:0] PC_STEP    = DAT_WIDTH'(DAT_WIDTH / 8);
    localparam logic [AW-1:0]        LAST_IDX   = AW'(NUM_REGS - 1);
    localparam logic [AW-1:0]        PC_IDX     = AW'(PC_REG);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_INIT  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [AW-1:0]               init_cnt_q, init_cnt_d;
    logic                        ready_q, ready_d;
    logic [DAT_WIDTH-1:0]        pc_q, pc_d;
    logic [NUM_RD*DAT_WIDTH-1:0] rd_dat_q, rd_dat_d;
    logic [DAT_WIDTH-1:0]        regs_q [NUM_REGS];
    logic [DAT_WIDTH-1:0]        regs_d [NUM_REGS];
    logic [DAT_WIDTH-1:0]        rd_src_s [NUM_REGS];
    logic [AW-1:0]               rd_id_s [NUM_RD];
    logic                        wr_ok_s;

    // Unpack the flat read-index bus into per-port indices.
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rd_id_s[k] = bus.rd_id_i[k*AW +: AW];
        end
    end

    // A write to register 0 is dropped when it is hardwired to zero.
    always_comb begin
        if (HARDWIRE_ZERO && (bus.wr_id_i == {AW{1'b0}})) begin
            wr_ok_s = 1'b0;
        end else begin
            wr_ok_s = bus.we_i;
        end
    end

    // Next-state of the FSM, init counter and ready flag.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_RESET: begin
                state_d    = ST_INIT;
                init_cnt_d = {AW{1'b0}};
            end
            ST_INIT: begin
                init_cnt_d = init_cnt_q + AW'(1);
                if (init_cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d    = ST_RESET;
                init_cnt_d = {AW{1'b0}};
            end
        endcase
        ready_d = (state_d == ST_RUN);
    end

    // Next register contents: init sweep, PC increment, then the write port
    // applied last so a write to the PC overrides a same-cycle increment.
    always_comb begin
        regs_d = regs_q;
        if (state_q == ST_INIT) begin
            if (init_cnt_q == PC_IDX) begin
                regs_d[init_cnt_q] = PC_RST_VAL;
            end else begin
                regs_d[init_cnt_q] = {DAT_WIDTH{1'b0}};
            end
        end else if (state_q == ST_RUN) begin
            if (bus.pc_inc_i) begin
                regs_d[PC_REG] = regs_q[PC_REG] + PC_STEP;
            end else begin
                regs_d[PC_REG] = regs_q[PC_REG];
            end
            if (wr_ok_s) begin
                regs_d[bus.wr_id_i] = bus.wr_dat_i;
            end else begin
                regs_d[bus.wr_id_i] = regs_d[bus.wr_id_i];
            end
        end else begin
            regs_d = regs_q;
        end
    end

    // Read source: post-edge contents when forwarding, pre-edge otherwise.
`ifdef REGFILE_BYPASS_EN
    assign rd_src_s = regs_d;
`else
    assign rd_src_s = regs_q;
`endif

    // Per-port read data; ports hold their value while not enabled.
    always_comb begin
        rd_dat_d = rd_dat_q;
        for (int k = 0; k < NUM_RD; k++) begin
            if ((state_q == ST_RUN) && bus.rd_en_i[k]) begin
                if (HARDWIRE_ZERO && (rd_id_s[k] == {AW{1'b0}})) begin
                    rd_dat_d[k*DAT_WIDTH +: DAT_WIDTH] = {DAT_WIDTH{1'b0}};
                end else begin
                    rd_dat_d[k*DAT_WIDTH +: DAT_WIDTH] = rd_src_s[rd_id_s[k]];
                end
            end else begin
                rd_dat_d[k*DAT_WIDTH +: DAT_WIDTH] = rd_dat_q[k*DAT_WIDTH +: DAT_WIDTH];
            end
        end
    end

    // PC mirror: follows the PC register once it has been initialised.
    always_comb begin
        pc_d = pc_q;
        if ((state_q == ST_INIT) && (init_cnt_q == PC_IDX)) begin
            pc_d = PC_RST_VAL;
        end else if (state_q == ST_RUN) begin
            pc_d = regs_d[PC_REG];
        end else begin
            pc_d = pc_q;
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_RESET;
            init_cnt_q <= {AW{1'b0}};
            ready_q    <= 1'b0;
            pc_q       <= {DAT_WIDTH{1'b0}};
            rd_dat_q   <= {(NUM_RD*DAT_WIDTH){1'b0}};
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            ready_q    <= ready_d;
            pc_q       <= pc_d;
            rd_dat_q   <= rd_dat_d;
        end
    end

    // Register storage; cleared by the init sweep rather than by reset.
    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            regs_q <= regs_d;
        end else begin
            regs_q <= regs_q;
        end
    end

    assign bus.ready_o  = ready_q;
    assign bus.pc_o     = pc_q;
    assign bus.rd_dat_o = rd_dat_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: init sweep length, parallel reads, PC
// increment/wrap/write priority, zero register (both HARDWIRE_ZERO settings),
// read-during-write and resets in the middle of INIT and RUN.
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_bad = 0;
    int   cnt;

    always #5 clk = ~clk;

    regfile_mp_if #(.DAT_WIDTH(64), .NUM_REGS(32), .NUM_RD(2)) bus ();
    regfile_mp_if #(.DAT_WIDTH(64), .NUM_REGS(32), .NUM_RD(2)) bus_nz ();

    regfile_mp #(.DAT_WIDTH(64), .NUM_REGS(32), .NUM_RD(2), .HARDWIRE_ZERO(1'b1)) u_dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus.slave)
    );

    regfile_mp #(.DAT_WIDTH(64), .NUM_REGS(32), .NUM_RD(2), .HARDWIRE_ZERO(1'b0)) u_dut_nz (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_nz.slave)
    );

    assign bus_nz.rd_en_i  = bus.rd_en_i;
    assign bus_nz.rd_id_i  = bus.rd_id_i;
    assign bus_nz.we_i     = bus.we_i;
    assign bus_nz.wr_id_i  = bus.wr_id_i;
    assign bus_nz.wr_dat_i = bus.wr_dat_i;
    assign bus_nz.pc_inc_i = bus.pc_inc_i;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.rd_en_i  = 2'b00;
        bus.rd_id_i  = 10'd0;
        bus.we_i     = 1'b0;
        bus.wr_id_i  = 5'd0;
        bus.wr_dat_i = 64'd0;
        bus.pc_inc_i = 1'b0;
    endtask

    task automatic wr(input logic [4:0] id, input logic [63:0] dat);
        bus.we_i     = 1'b1;
        bus.wr_id_i  = id;
        bus.wr_dat_i = dat;
        tick();
        bus.we_i     = 1'b0;
    endtask

    // Issue one read on both ports (port0 = id0, port1 = id1) and check both.
    task automatic rd2(input string tag, input logic [4:0] id1, input logic [4:0] id0,
                       input logic [63:0] exp1, input logic [63:0] exp0);
        bus.rd_en_i = 2'b11;
        bus.rd_id_i = {id1, id0};
        tick();
        bus.rd_en_i = 2'b00;
        chk(tag, {64'd0, bus.rd_dat_o[63:0]}, {64'd0, exp0});
        chk(tag, {64'd0, bus.rd_dat_o[127:64]}, {64'd0, exp1});
    endtask

    task automatic wait_ready(input string tag);
        cnt = 0;
        while (!bus.ready_o && cnt < 100) begin
            tick();
            cnt++;
        end
        chk(tag, 128'(cnt), 128'd32);
    endtask

    initial begin
        idle();
        tick();
        tick();
        chk("rst_ready", {127'd0, bus.ready_o}, 128'd0);
        chk("rst_rd", bus.rd_dat_o, 128'd0);
        chk("rst_pc", {64'd0, bus.pc_o}, 128'd0);

        // 1. init sweep
        rst_n = 1'b1;
        tick();
        chk("init_ready_low", {127'd0, bus.ready_o}, 128'd0);
        wait_ready("init_len");
        chk("init_pc", {64'd0, bus.pc_o}, {64'd0, 64'h0000_8000_0000_0000});
        for (int i = 0; i < 30; i += 2) begin
            rd2("init_zero", 5'(i + 1), 5'(i), 64'd0, 64'd0);
        end
        rd2("init_r31", 5'd31, 5'd30, 64'h0000_8000_0000_0000, 64'd0);

        // 2. parallel reads and hold
        wr(5'd3, 64'hA5);
        wr(5'd7, 64'h5A);
        rd2("par_rd", 5'd7, 5'd3, 64'h5A, 64'hA5);
        bus.rd_id_i = {5'd0, 5'd0};
        tick();
        tick();
        chk("par_hold", bus.rd_dat_o, {64'h5A, 64'hA5});

        // 3. PC increment, wrap, write priority
        bus.pc_inc_i = 1'b1;
        tick();
        tick();
        tick();
        bus.pc_inc_i = 1'b0;
        chk("pc_inc3", {64'd0, bus.pc_o}, {64'd0, 64'h0000_8000_0000_0018});
        wr(5'd31, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("pc_wr", {64'd0, bus.pc_o}, {64'd0, 64'hFFFF_FFFF_FFFF_FFF8});
        bus.pc_inc_i = 1'b1;
        tick();
        bus.pc_inc_i = 1'b0;
        chk("pc_wrap", {64'd0, bus.pc_o}, 128'd0);
        bus.pc_inc_i = 1'b1;
        wr(5'd31, 64'h1000);
        bus.pc_inc_i = 1'b0;
        chk("pc_wr_wins", {64'd0, bus.pc_o}, {64'd0, 64'h1000});
        rd2("pc_reg", 5'd31, 5'd3, 64'h1000, 64'hA5);

        // 4. zero register
        wr(5'd0, 64'hDEAD);
        rd2("r0_hz", 5'd0, 5'd0, 64'd0, 64'd0);
        chk("r0_nohz", {64'd0, bus_nz.rd_dat_o[63:0]}, {64'd0, 64'hDEAD});

        // 5. read-during-write
        wr(5'd5, 64'd1);
        bus.we_i     = 1'b1;
        bus.wr_id_i  = 5'd5;
        bus.wr_dat_i = 64'd2;
        bus.rd_en_i  = 2'b01;
        bus.rd_id_i  = {5'd0, 5'd5};
        tick();
        idle();
`ifdef REGFILE_BYPASS_EN
        chk("rdw_same", {64'd0, bus.rd_dat_o[63:0]}, {64'd0, 64'd2});
`else
        chk("rdw_same", {64'd0, bus.rd_dat_o[63:0]}, {64'd0, 64'd1});
`endif
        rd2("rdw_next", 5'd5, 5'd5, 64'd2, 64'd2);
        // read of PC during a lone increment
        bus.pc_inc_i = 1'b1;
        bus.rd_en_i  = 2'b01;
        bus.rd_id_i  = {5'd0, 5'd31};
        tick();
        idle();
`ifdef REGFILE_BYPASS_EN
        chk("rdw_pc", {64'd0, bus.rd_dat_o[63:0]}, {64'd0, 64'h1008});
`else
        chk("rdw_pc", {64'd0, bus.rd_dat_o[63:0]}, {64'd0, 64'h1000});
`endif
        chk("rdw_pc_o", {64'd0, bus.pc_o}, {64'd0, 64'h1008});

        // 6. reset during a write burst, then again mid-INIT
        rd2("pre_rst", 5'd31, 5'd7, 64'h1008, 64'h5A);
        bus.we_i     = 1'b1;
        bus.wr_id_i  = 5'd4;
        bus.wr_dat_i = 64'h11;
        tick();
        bus.wr_dat_i = 64'h22;
        rst_n = 1'b0;
        tick();
        chk("run_rst_ready", {127'd0, bus.ready_o}, 128'd0);
        chk("run_rst_rd", bus.rd_dat_o, 128'd0);
        chk("run_rst_pc", {64'd0, bus.pc_o}, 128'd0);
        rst_n = 1'b1;
        bus.wr_dat_i = 64'hBEEF;
        bus.pc_inc_i = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        rst_n = 1'b0;
        tick();
        chk("init_rst_ready", {127'd0, bus.ready_o}, 128'd0);
        chk("init_rst_rd", bus.rd_dat_o, 128'd0);
        rst_n = 1'b1;
        tick();
        wait_ready("init_len2");
        idle();
        chk("init2_pc", {64'd0, bus.pc_o}, {64'd0, 64'h0000_8000_0000_0000});
        rd2("init2_r4", 5'd31, 5'd4, 64'h0000_8000_0000_0000, 64'd0);
        rd2("init2_r3", 5'd7, 5'd3, 64'd0, 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
